buzz_sequencer: RTL and testbench
=================================

BUZZ_SEQUENCER -- requirements
Module: buzz_sequencer

Interface
REQ-001 SHALL have parameter NOTE_TICKS, default 12000000, TONE-phase length per note in clk cycles (min 1).
REQ-002 SHALL have parameter GAP_TICKS, default 1200000, silent GAP-phase length after each note in clk cycles (min 1).
REQ-003 SHALL have parameter DIV_SHIFT, default 0, right-shift applied to every note-table half-period (simulation speed-up).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin the song.
REQ-007 stop  input  1  abort request, honoured in any state.
REQ-008 eout  output  1  buzzer square-wave drive.
REQ-009 busy  output  1  high while in TONE or GAP.
REQ-010 done  output  1  single-cycle pulse on normal song completion.
REQ-011 note_idx  output  3  index of the note being played.

Function
REQ-012 SHALL hold a fixed 8-entry, 16-bit half-period table (12 MHz clk, C4..C5): 22933, 20431, 18202, 17181, 15306, 13636, 12149, 11467.
REQ-013 Effective half-period H SHALL be table[note_idx] >> DIV_SHIFT; H==0 SHALL be a rest (eout held 0 for the whole TONE phase).
REQ-014 FSM states SHALL be IDLE, TONE and GAP; reset state IDLE.
REQ-015 IDLE: start=1 and stop=0 -> TONE next cycle; note_idx=0, tone and duration counters cleared, eout=0, busy=1.
REQ-016 TONE: tone counter SHALL count 0..H-1 and toggle eout on reaching H-1, so the first toggle occurs H cycles after TONE entry and the period is 2*H cycles.
REQ-017 TONE SHALL last exactly NOTE_TICKS cycles, then go to GAP with eout forced 0 on the first GAP cycle.
REQ-018 GAP SHALL last exactly GAP_TICKS cycles with eout=0; then, if note_idx<7, increment note_idx and re-enter TONE with the tone counter cleared.
REQ-019 GAP end with note_idx==7 and BUZZ_LOOP_EN undefined -> IDLE, done=1 for that one cycle, busy=0, note_idx=0.
REQ-020 stop=1 in any state -> IDLE next cycle, eout=0, busy=0, note_idx=0, no done pulse; stop has priority over start on the same cycle.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Duration counters SHALL be 32 bits wide; tone counter 16 bits; no counter SHALL wrap within its phase.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, eout=0, busy=0, done=0, note_idx=0 and clear all counters, overriding start/stop and aborting any song mid-note.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Configuration
REQ-025 Macro BUZZ_LOOP_EN defined: GAP end at note_idx==7 SHALL wrap note_idx to 0 and re-enter TONE, busy stays 1, done is never asserted; only stop or rst ends playback.
REQ-026 BUZZ_LOOP_EN undefined: behaviour per REQ-019; the song plays once.

Verification (NOTE_TICKS=20, GAP_TICKS=4, DIV_SHIFT=12 unless stated)
REQ-027 rst held 2 cycles, then start pulse -> next cycle busy=1, note_idx=0; eout first toggles 5 cycles after TONE entry (H=22933>>12=5), period 10 cycles.
REQ-028 Full song, loop disabled -> eout 0 during each 4-cycle GAP; note_idx steps 0..7; done pulses exactly once 192 cycles after TONE entry; busy then 0.
REQ-029 stop asserted on cycle 8 of note 3 -> next cycle IDLE, eout=0, busy=0, done never asserted.
REQ-030 start and stop together in IDLE -> stays IDLE; start re-pulsed during TONE -> note_idx and counters unaffected.
REQ-031 DIV_SHIFT=15 (all H=0) -> eout stays 0 for the whole song, done still pulses after 192 cycles.
REQ-032 BUZZ_LOOP_EN defined -> after note 7 GAP, note_idx=0 and TONE re-entered, done stays 0 over 3 passes, stop returns to IDLE.

Source files
------------

// File: rtl/buzz_sequencer.sv
// rtl/buzz_sequencer.sv - eight-note C4..C5 buzzer song sequencer with registered outputs
// Optional macro BUZZ_LOOP_EN: replay the song continuously until stop or rst.
module buzz_sequencer #(
  parameter int NOTE_TICKS = 12000000,
  parameter int GAP_TICKS  = 1200000,
  parameter int DIV_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       eout,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

  state_t      state, state_n;
  logic [15:0] tone_cnt, tone_cnt_n;
  logic [31:0] dur_cnt, dur_cnt_n;
  logic [2:0]  note_n;
  logic        eout_n, busy_n, done_n;
  logic [15:0] half_raw, half;

  // Half-periods in 12 MHz clk cycles; a shifted value of 0 plays as a rest
  always_comb begin
    case (note_idx)
      3'd0:    half_raw = 16'd22933;
      3'd1:    half_raw = 16'd20431;
      3'd2:    half_raw = 16'd18202;
      3'd3:    half_raw = 16'd17181;
      3'd4:    half_raw = 16'd15306;
      3'd5:    half_raw = 16'd13636;
      3'd6:    half_raw = 16'd12149;
      default: half_raw = 16'd11467;
    endcase
    half = half_raw >> DIV_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tone_cnt <= 16'd0;
      dur_cnt  <= 32'd0;
      note_idx <= 3'd0;
      eout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tone_cnt <= tone_cnt_n;
      dur_cnt  <= dur_cnt_n;
      note_idx <= note_n;
      eout     <= eout_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tone_cnt_n = tone_cnt;
    dur_cnt_n  = dur_cnt;
    note_n     = note_idx;
    eout_n     = eout;
    busy_n     = busy;
    done_n     = 1'b0;
    if (stop) begin
      state_n    = IDLE;
      tone_cnt_n = 16'd0;
      dur_cnt_n  = 32'd0;
      note_n     = 3'd0;
      eout_n     = 1'b0;
      busy_n     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n    = TONE;
            tone_cnt_n = 16'd0;
            dur_cnt_n  = 32'd0;
            note_n     = 3'd0;
            eout_n     = 1'b0;
            busy_n     = 1'b1;
          end
        end
        TONE: begin
          if (half != 16'd0) begin
            if (tone_cnt == half - 16'd1) begin
              tone_cnt_n = 16'd0;
              eout_n     = ~eout;
            end else begin
              tone_cnt_n = tone_cnt + 16'd1;
            end
          end
          // End of note wins over a coincident toggle so GAP starts silent
          if (dur_cnt == NOTE_LAST) begin
            state_n    = GAP;
            dur_cnt_n  = 32'd0;
            tone_cnt_n = 16'd0;
            eout_n     = 1'b0;
          end else begin
            dur_cnt_n = dur_cnt + 32'd1;
          end
        end
        GAP: begin
          eout_n = 1'b0;
          if (dur_cnt == GAP_LAST) begin
            dur_cnt_n  = 32'd0;
            tone_cnt_n = 16'd0;
            if (note_idx != 3'd7) begin
              note_n  = note_idx + 3'd1;
              state_n = TONE;
            end else begin
`ifdef BUZZ_LOOP_EN
              note_n  = 3'd0;
              state_n = TONE;
`else
              note_n  = 3'd0;
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
`endif
            end
          end else begin
            dur_cnt_n = dur_cnt + 32'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buzz_sequencer.sv
// tb/tb_buzz_sequencer.sv - randomized self-checking bench for buzz_sequencer
// Honours BUZZ_LOOP_EN when the same macro is given to the build.
module tb_buzz_sequencer;

  localparam int NT   = 20;
  localparam int GT   = 4;
  localparam int SONG = 8 * (NT + GT);

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic       eout, busy, done;
  logic [2:0] note_idx;
  logic       eout15, busy15, done15;
  logic [2:0] note15;

  int checks = 0;
  int errors = 0;
  int tbl[8] = '{22933, 20431, 18202, 17181, 15306, 13636, 12149, 11467};

  always #5 clk = ~clk;

  buzz_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .DIV_SHIFT(12)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .eout(eout), .busy(busy), .done(done), .note_idx(note_idx)
  );

  buzz_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .DIV_SHIFT(15)) dut15 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .eout(eout15), .busy(busy15), .done(done15), .note_idx(note15)
  );

  // Expected outputs c cycles after TONE entry, from song timing arithmetic
  function automatic void model(input int c, input int shift, input bit stopped,
                                output bit e, output bit b, output bit d, output int n);
    int w, h, cc;
    e = 0; b = 0; d = 0; n = 0;
    if (stopped) return;
`ifdef BUZZ_LOOP_EN
    cc = c % SONG;
`else
    if (c >= SONG) begin
      d = (c == SONG);
      return;
    end
    cc = c;
`endif
    b = 1;
    n = cc / (NT + GT);
    w = cc % (NT + GT);
    h = tbl[n] >> shift;
    if (w < NT && h != 0) e = ((w / h) % 2) == 1;
  endfunction

  task automatic play(input string name, input int ncyc, input int stop_at, input bit noise);
    bit e, b, d, stopped;
    int n;
    @(negedge clk); start = 1; stop = 0;
    @(negedge clk); start = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      stopped = (stop_at >= 0) && (c > stop_at);
      model(c, 12, stopped, e, b, d, n);
      checks += 4;
      if (eout !== e) begin errors++; $display("FAIL %s eout c=%0d got %b exp %b", name, c, eout, e); end
      if (busy !== b) begin errors++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, b); end
      if (done !== d) begin errors++; $display("FAIL %s done c=%0d got %b exp %b", name, c, done, d); end
      if (note_idx !== 3'(n)) begin errors++; $display("FAIL %s note_idx c=%0d got %0d exp %0d", name, c, note_idx, n); end
      model(c, 15, stopped, e, b, d, n);
      checks += 2;
      if (eout15 !== e) begin errors++; $display("FAIL %s rest_eout c=%0d got %b exp %b", name, c, eout15, e); end
      if (done15 !== d) begin errors++; $display("FAIL %s rest_done c=%0d got %b exp %b", name, c, done15, d); end
      stop  = (c == stop_at);
      start = noise && !stopped && (c < SONG) && ($urandom_range(0, 3) == 0);
    end
    start = 0; stop = 0;
  endtask

  task automatic test_reset;
    rst = 1; start = 1; stop = 0;
    repeat (2) begin
      @(negedge clk);
      checks += 4;
      if (eout !== 1'b0) begin errors++; $display("FAIL reset eout got %b exp 0", eout); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
      if (note_idx !== 3'd0) begin errors++; $display("FAIL reset note_idx got %0d exp 0", note_idx); end
    end
    rst = 0; start = 0;
  endtask

  task automatic test_start_stop_idle;
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    repeat (3) begin
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle busy got %b exp 0", busy); end
      if (eout !== 1'b0) begin errors++; $display("FAIL start_stop_idle eout got %b exp 0", eout); end
      if (note_idx !== 3'd0) begin errors++; $display("FAIL start_stop_idle note_idx got %0d exp 0", note_idx); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midsong;
    int k;
    k = $urandom_range(1, SONG - 10);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (k) @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk); rst = 0; start = 0;
    checks += 4;
    if (eout !== 1'b0) begin errors++; $display("FAIL reset_midsong eout got %b exp 0", eout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_midsong busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_midsong done got %b exp 0", done); end
    if (note_idx !== 3'd0) begin errors++; $display("FAIL reset_midsong note_idx got %0d exp 0", note_idx); end
    @(negedge clk);
    checks += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_midsong idle busy got %b exp 0", busy); end
  endtask

  task automatic test_full_song;
`ifdef BUZZ_LOOP_EN
    play("loop_song", 3 * SONG + 5, 3 * SONG + 2, 1'b1);
`else
    play("full_song", SONG + 3, -1, 1'b1);
`endif
  endtask

  task automatic test_stop;
    play("stop_note3", 3 * (NT + GT) + 8 + 5, 3 * (NT + GT) + 8, 1'b0);
  endtask

  task automatic test_random_stop;
    int s;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? SONG - 1 : $urandom_range(0, SONG - 1);
      play("random_stop", s + 5, s, 1'b1);
    end
  endtask

  initial begin
    rst = 1; start = 0; stop = 0;
    test_reset();
    test_start_stop_idle();
    test_full_song();
    test_stop();
    test_random_stop();
    test_reset_midsong();
    test_full_song();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
